// File: rtl/fetch_control_if.sv
// Fetch / ID-stage signal bundle. fetch_control takes the master side (it
// steers fetch); the fetch stage and the execute-side environment take the slave side.
interface fetch_control_if #(
    parameter int WIDTH = 32'd16
);
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] Instruction;
    logic             Zero;
    logic             exReady;
    logic             BranchTK;
    logic             IncreaseTK;
    logic [WIDTH-1:0] Broffset;
    logic [WIDTH-1:0] idInstr;
    logic [WIDTH-1:0] idPC;
    logic             idValid;

    modport master (
        input  PC, Instruction, Zero, exReady,
        output BranchTK, IncreaseTK, Broffset, idInstr, idPC, idValid
    );

    modport slave (
        output PC, Instruction, Zero, exReady,
        input  BranchTK, IncreaseTK, Broffset, idInstr, idPC, idValid
    );
endinterface

// File: rtl/fetch_control.sv
// IF/ID pipeline register plus branch resolution and MUL / back-pressure
// stalling that steers the fetch stage's PC register.
module fetch_control #(
    parameter int WIDTH      = 32'd16,
    parameter int MUL_CYCLES = 32'd3
) (
    input  logic           clk,
    input  logic           nReset,
    fetch_control_if.master bus
);
    localparam int CNT_W = $clog2(MUL_CYCLES) + 32'd1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_BZ  = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hB;
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] PC_STEP   = {{(WIDTH-2){1'b0}}, 2'b10};

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] id_instr_r;
    logic [WIDTH-1:0] id_pc_r;
    logic             id_valid_r;

    logic [3:0]       opcode_s;
    logic [WIDTH-1:0] offset_s;
    logic [WIDTH-1:0] target_s;
    logic             taken_s;
    logic             is_mul_s;
    logic             branch_s;
    logic             increase_s;

    // Decode the ID slot: opcode, word offset and absolute branch target.
    always_comb begin
        opcode_s = id_instr_r[WIDTH-1 -: 4];
        if (opcode_s == OP_JMP) begin
            offset_s = {{(WIDTH-12){id_instr_r[11]}}, id_instr_r[11:0]};
        end else begin
            offset_s = {{(WIDTH-8){id_instr_r[7]}}, id_instr_r[7:0]};
        end
        target_s = id_pc_r + PC_STEP + {offset_s[WIDTH-2:0], 1'b0};
        taken_s  = id_valid_r && bus.exReady &&
                   ((opcode_s == OP_JMP) || ((opcode_s == OP_BZ) && bus.Zero));
        is_mul_s = id_valid_r && (opcode_s == OP_MUL);
    end

    // Fetch steering; both controls are forced low while reset is held.
    always_comb begin
        branch_s   = 1'b0;
        increase_s = 1'b0;
        if (!nReset) begin
            branch_s   = 1'b0;
            increase_s = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (!bus.exReady) begin
                        branch_s   = 1'b0;
                        increase_s = 1'b0;
                    end else if (taken_s) begin
                        branch_s   = 1'b1;
                        increase_s = 1'b0;
                    end else if (is_mul_s) begin
                        branch_s   = 1'b0;
                        increase_s = 1'b0;
                    end else begin
                        branch_s   = 1'b0;
                        increase_s = 1'b1;
                    end
                end
                STALL: begin
                    branch_s   = 1'b0;
                    increase_s = (cnt_r == CNT_ONE) && bus.exReady;
                end
                default: begin
                    branch_s   = 1'b0;
                    increase_s = 1'b0;
                end
            endcase
        end
    end

    // IF/ID register and RUN/STALL sequencing; bubbles keep the last idPC.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r    <= RUN;
            cnt_r      <= CNT_ZERO;
            id_instr_r <= WORD_ZERO;
            id_pc_r    <= WORD_ZERO;
            id_valid_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (!bus.exReady) begin
                        state_r <= RUN;
                    end else if (taken_s) begin
                        id_instr_r <= WORD_ZERO;
                        id_valid_r <= 1'b0;
                    end else if (is_mul_s) begin
                        id_instr_r <= WORD_ZERO;
                        id_valid_r <= 1'b0;
                        cnt_r      <= CNT_LOAD;
                        state_r    <= STALL;
                    end else begin
                        id_instr_r <= bus.Instruction;
                        id_pc_r    <= bus.PC;
                        id_valid_r <= 1'b1;
                    end
                end
                STALL: begin
                    // The countdown ignores exReady; only the final release waits on it.
                    if (cnt_r > CNT_ONE) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (bus.exReady) begin
                        id_instr_r <= bus.Instruction;
                        id_pc_r    <= bus.PC;
                        id_valid_r <= 1'b1;
                        cnt_r      <= CNT_ZERO;
                        state_r    <= RUN;
                    end else begin
                        cnt_r <= CNT_ONE;
                    end
                end
                default: begin
                    state_r <= RUN;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.BranchTK   = branch_s;
    assign bus.IncreaseTK = increase_s;
    assign bus.Broffset   = target_s;
    assign bus.idInstr    = id_instr_r;
    assign bus.idPC       = id_pc_r;
    assign bus.idValid    = id_valid_r;
endmodule
